// File: rtl/sorter_param.sv
// In-place selection-exchange sorter over a DEPTH x WIDTH register file.
// The host loads and reads the file; on start the contents are sorted in place and swaps are counted.
//
// state | meaning
// IDLE  | waiting for start, host port may write
// RDI   | fetch word i into A, set j = i+1
// RDJ   | fetch word j into B
// CMP   | decide whether A and B are out of order
// WRJ   | write A to slot j
// WRI   | write B to slot i, A takes B, count the swap
// NXT   | advance j, or i when j reaches the end
// DONE  | sort finished, host port may write, results held
module sorter_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 0,
    localparam int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              desc,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       swap_cnt
);

    typedef enum logic [2:0] {IDLE, RDI, RDJ, CMP, WRJ, WRI, NXT, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(DEPTH - 2);

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [ADDR_W-1:0] i_idx;
    logic [ADDR_W-1:0] j_idx;
    logic              desc_q;

    logic              idle_like;
    logic              host_we;
    logic              a_gt_b;
    logic              a_lt_b;
    logic              swap_now;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign host_we   = wr_en && idle_like && (int'(wr_addr) < DEPTH);

    if (SIGNED != 0) begin : g_signed_cmp
        assign a_gt_b = $signed(a_reg) > $signed(b_reg);
        assign a_lt_b = $signed(a_reg) < $signed(b_reg);
    end else begin : g_unsigned_cmp
        assign a_gt_b = a_reg > b_reg;
        assign a_lt_b = a_reg < b_reg;
    end

    assign swap_now = desc_q ? a_lt_b : a_gt_b;

    // A reset landing on WRJ suppresses that write, while WRI always completes,
    // so an interrupted swap never duplicates or drops a word.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (host_we) begin
            mem_we = 1'b1;
        end else if (state == WRJ && !rst) begin
            mem_we    = 1'b1;
            mem_addr  = j_idx;
            mem_wdata = a_reg;
        end else if (state == WRI) begin
            mem_we    = 1'b1;
            mem_addr  = i_idx;
            mem_wdata = b_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            swap_cnt <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            desc_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        desc_q   <= desc;
                        swap_cnt <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        i_idx    <= '0;
                        state    <= RDI;
                    end
                end
                RDI: begin
                    a_reg <= mem[i_idx];
                    j_idx <= i_idx + ADDR_W'(1);
                    state <= RDJ;
                end
                RDJ: begin
                    b_reg <= mem[j_idx];
                    state <= CMP;
                end
                CMP: begin
                    state <= swap_now ? WRJ : NXT;
                end
                WRJ: begin
                    state <= WRI;
                end
                WRI: begin
                    a_reg <= b_reg;
                    if (swap_cnt != 16'hFFFF) begin
                        swap_cnt <= swap_cnt + 16'd1;
                    end
                    state <= NXT;
                end
                NXT: begin
                    if (j_idx == LAST_J) begin
                        if (i_idx == LAST_I) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            i_idx <= i_idx + ADDR_W'(1);
                            state <= RDI;
                        end
                    end else begin
                        j_idx <= j_idx + ADDR_W'(1);
                        state <= RDJ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_param.sv
// Bench for sorter_param: three instances (8x8 unsigned, 6x8 signed, 2x16 unsigned).
// Read expectations go through a scoreboard queue and are popped when rd_data is valid.
module tb_sorter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start0, desc0, wr_en0;
    logic [2:0]  wr_addr0, rd_addr0;
    logic [7:0]  wr_data0, rd_data0;
    logic        busy0, done0;
    logic [15:0] swap0;

    logic        start1, desc1, wr_en1;
    logic [2:0]  wr_addr1, rd_addr1;
    logic [7:0]  wr_data1, rd_data1;
    logic        busy1, done1;
    logic [15:0] swap1;

    logic        start2, desc2, wr_en2;
    logic [0:0]  wr_addr2, rd_addr2;
    logic [15:0] wr_data2, rd_data2;
    logic        busy2, done2;
    logic [15:0] swap2;

    sorter_param #(.WIDTH(8), .DEPTH(8), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .desc(desc0), .wr_en(wr_en0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .swap_cnt(swap0));

    sorter_param #(.WIDTH(8), .DEPTH(6), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .desc(desc1), .wr_en(wr_en1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .swap_cnt(swap1));

    sorter_param #(.WIDTH(16), .DEPTH(2), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .desc(desc2), .wr_en(wr_en2),
        .wr_addr(wr_addr2), .wr_data(wr_data2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .busy(busy2), .done(done2), .swap_cnt(swap2));

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_rd(input int sel);
        case (sel)
            0:       return 32'(rd_data0);
            1:       return 32'(rd_data1);
            default: return 32'(rd_data2);
        endcase
    endfunction

    function automatic logic obs_busy(input int sel);
        case (sel)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic obs_done(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [31:0] obs_swap(input int sel);
        case (sel)
            0:       return 32'(swap0);
            1:       return 32'(swap1);
            default: return 32'(swap2);
        endcase
    endfunction

    // Reference selection-exchange: number of swaps for n values in order d.
    function automatic int model_swaps(input int v_in[8], input int n, input bit d);
        int v[8];
        int sw = 0;
        int t;
        v = v_in;
        for (int i = 0; i < n - 1; i++) begin
            for (int j = i + 1; j < n; j++) begin
                if (d ? (v[i] < v[j]) : (v[i] > v[j])) begin
                    t = v[i]; v[i] = v[j]; v[j] = t;
                    sw++;
                end
            end
        end
        return sw;
    endfunction

    task automatic wr(input int sel, input int a, input logic [31:0] d);
        @(negedge clk);
        case (sel)
            0:       begin wr_en0 = 1'b1; wr_addr0 = 3'(a); wr_data0 = d[7:0];  end
            1:       begin wr_en1 = 1'b1; wr_addr1 = 3'(a); wr_data1 = d[7:0];  end
            default: begin wr_en2 = 1'b1; wr_addr2 = 1'(a); wr_data2 = d[15:0]; end
        endcase
        @(negedge clk);
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_en2 = 1'b0;
    endtask

    task automatic set_rd(input int sel, input int a);
        case (sel)
            0:       rd_addr0 = 3'(a);
            1:       rd_addr1 = 3'(a);
            default: rd_addr2 = 1'(a);
        endcase
    endtask

    task automatic rd_exp(input int sel, input int a, input logic [31:0] e, input string tag);
        @(negedge clk);
        set_rd(sel, a);
        sb_q.push_back(e);
        @(negedge clk);
        chk(tag, obs_rd(sel), sb_q.pop_front());
    endtask

    task automatic rd_val(input int sel, input int a, output logic [31:0] v);
        @(negedge clk);
        set_rd(sel, a);
        @(negedge clk);
        v = obs_rd(sel);
    endtask

    // Starts a sort and counts busy cycles; optional reset at cycle rst_at and
    // an attempted write/start at cycle 5 when interfere is set (instance 0 only).
    task automatic run_sort(input int sel, input bit d, input int rst_at,
                            input bit interfere, output int cyc);
        @(negedge clk);
        case (sel)
            0:       begin start0 = 1'b1; desc0 = d; end
            1:       begin start1 = 1'b1; desc1 = d; end
            default: begin start2 = 1'b1; desc2 = d; end
        endcase
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        chk("busy_rise", 32'(obs_busy(sel)), 32'd1);
        chk("done_clear", 32'(obs_done(sel)), 32'd0);
        cyc = 0;
        while (obs_busy(sel) && cyc < 5000) begin
            cyc++;
            if (interfere && cyc == 5) begin
                wr_en0 = 1'b1; wr_addr0 = 3'd0; wr_data0 = 8'd0;
                start0 = 1'b1; desc0 = ~d;
            end else begin
                wr_en0 = 1'b0; start0 = 1'b0;
            end
            rst = (cyc == rst_at);
            @(negedge clk);
        end
        rst = 1'b0; wr_en0 = 1'b0; start0 = 1'b0;
        chk("sort_bound", 32'(cyc < 5000), 32'd1);
    endtask

    int t1_in[8]   = '{90, 25, 60, 15, 30, 75, 45, 10};
    int t1_asc[8]  = '{10, 15, 25, 30, 45, 60, 75, 90};
    int t1_desc[8] = '{90, 75, 60, 45, 30, 25, 15, 10};
    int s_in[8]    = '{127, -128, 0, -1, 1, -2, 0, 0};
    logic [7:0] s_raw[6] = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'hFE};
    logic [7:0] s_exp[6] = '{8'h80, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h7F};

    initial begin
        int cyc;
        int sw;
        int cnt;
        int perm[8];
        int ones[8];
        logic [31:0] v;

        rst = 1'b1;
        start0 = 0; desc0 = 0; wr_en0 = 0; wr_addr0 = 0; wr_data0 = 0; rd_addr0 = 0;
        start1 = 0; desc1 = 0; wr_en1 = 0; wr_addr1 = 0; wr_data1 = 0; rd_addr1 = 0;
        start2 = 0; desc2 = 0; wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0; rd_addr2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_swap", 32'(swap0), 32'd0);
        chk("rst_rd_data", 32'(rd_data0), 32'd0);
        chk("rst_busy_s", 32'(busy1), 32'd0);
        chk("rst_busy_d2", 32'(busy2), 32'd0);
        rst = 1'b0;

        // T1 ascending
        for (int k = 0; k < 8; k++) wr(0, k, 32'(t1_in[k]));
        sw = model_swaps(t1_in, 8, 1'b0);
        run_sort(0, 1'b0, 0, 1'b0, cyc);
        chk("t1_done", 32'(done0), 32'd1);
        chk("t1_swaps", obs_swap(0), 32'(sw));
        chk("t1_busy_len", 32'(cyc), 32'(91 + 2 * sw));
        for (int k = 0; k < 8; k++) rd_exp(0, k, 32'(t1_asc[k]), "t1_rd");

        // T2 descending
        for (int k = 0; k < 8; k++) wr(0, k, 32'(t1_in[k]));
        sw = model_swaps(t1_in, 8, 1'b1);
        run_sort(0, 1'b1, 0, 1'b0, cyc);
        chk("t2_done", 32'(done0), 32'd1);
        chk("t2_swaps", obs_swap(0), 32'(sw));
        chk("t2_busy_len", 32'(cyc), 32'(91 + 2 * sw));
        for (int k = 0; k < 8; k++) rd_exp(0, k, 32'(t1_desc[k]), "t2_rd");

        // T3 already sorted, then all equal
        for (int k = 0; k < 8; k++) wr(0, k, 32'(k + 1));
        run_sort(0, 1'b0, 0, 1'b0, cyc);
        chk("t3_swaps", obs_swap(0), 32'd0);
        chk("t3_busy_len", 32'(cyc), 32'd91);
        for (int k = 0; k < 8; k++) wr(0, k, 32'hAA);
        run_sort(0, 1'b0, 0, 1'b0, cyc);
        chk("t3_eq_swaps", obs_swap(0), 32'd0);
        chk("t3_eq_busy_len", 32'(cyc), 32'd91);
        for (int k = 0; k < 8; k++) rd_exp(0, k, 32'hAA, "t3_eq_rd");

        // T5 reset mid-sort, with write/start attempted while busy
        for (int k = 0; k < 8; k++) wr(0, k, 32'(t1_in[k]));
        run_sort(0, 1'b0, 20, 1'b1, cyc);
        chk("t5_rst_cycle", 32'(cyc), 32'd20);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_done", 32'(done0), 32'd0);
        chk("t5_swap", 32'(swap0), 32'd0);
        for (int k = 0; k < 8; k++) begin
            rd_val(0, k, v);
            perm[k] = int'(v);
        end
        for (int k = 0; k < 8; k++) begin
            cnt = 0;
            for (int m = 0; m < 8; m++) if (perm[m] == t1_in[k]) cnt++;
            ones[k] = cnt;
        end
        for (int k = 0; k < 8; k++) chk("t5_perm", 32'(ones[k]), 32'd1);
        sw = model_swaps(perm, 8, 1'b0);
        run_sort(0, 1'b0, 0, 1'b1, cyc);
        chk("t5_re_done", 32'(done0), 32'd1);
        chk("t5_re_swaps", obs_swap(0), 32'(sw));
        chk("t5_re_busy_len", 32'(cyc), 32'(91 + 2 * sw));
        for (int k = 0; k < 8; k++) rd_exp(0, k, 32'(t1_asc[k]), "t5_re_rd");

        // T4 signed compare, DEPTH=6 with out-of-range addresses
        for (int k = 0; k < 6; k++) wr(1, k, 32'(s_raw[k]));
        wr(1, 7, 32'h55);
        sw = model_swaps(s_in, 6, 1'b0);
        run_sort(1, 1'b0, 0, 1'b0, cyc);
        chk("t4_done", 32'(done1), 32'd1);
        chk("t4_swaps", obs_swap(1), 32'(sw));
        chk("t4_busy_len", 32'(cyc), 32'(5 + 45 + 2 * sw));
        for (int k = 0; k < 6; k++) rd_exp(1, k, 32'(s_exp[k]), "t4_rd");
        rd_exp(1, 6, 32'd0, "t4_rd_oob6");
        rd_exp(1, 7, 32'd0, "t4_rd_oob7");

        // T6 DEPTH=2, WIDTH=16
        wr(2, 0, 32'd5);
        wr(2, 1, 32'd3);
        run_sort(2, 1'b0, 0, 1'b0, cyc);
        chk("t6_swaps", obs_swap(2), 32'd1);
        chk("t6_busy_len", 32'(cyc), 32'd6);
        rd_exp(2, 0, 32'd3, "t6_rd0");
        rd_exp(2, 1, 32'd5, "t6_rd1");
        run_sort(2, 1'b0, 0, 1'b0, cyc);
        chk("t6_re_swaps", obs_swap(2), 32'd0);
        chk("t6_re_busy_len", 32'(cyc), 32'd4);
        chk("t6_re_done", 32'(done2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
